// File: rtl/register_file.sv
// Bank of eight NBits registers (T1-T4, R1-R4) sharing one write function,
// each gated by its own enable bit, with two combinational read ports.
module register_file #(
    parameter int NBits = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NBits-1:0] i,
    input  logic [1:0]       funsel,
    input  logic [3:0]       rsel,
    input  logic [3:0]       tsel,
    input  logic [2:0]       o1sel,
    input  logic [2:0]       o2sel,
    output logic [NBits-1:0] o1,
    output logic [NBits-1:0] o2
);

    // Storage is indexed by the read-select code: 0..3 = T1..T4, 4..7 = R1..R4.
    logic [NBits-1:0] regs_q [8];
    logic [NBits-1:0] regs_d [8];
    logic [7:0]       en_s;

    function automatic logic [NBits-1:0] next_val(
        input logic [NBits-1:0] q,
        input logic [1:0]       fs,
        input logic [NBits-1:0] din
    );
        logic [NBits-1:0] r;
        case (fs)
            2'b00:   r = '0;
            2'b01:   r = din;
            2'b10:   r = q - {{(NBits-1){1'b0}}, 1'b1};
            2'b11:   r = q + {{(NBits-1){1'b0}}, 1'b1};
            default: r = q;
        endcase
        return r;
    endfunction

    // Enable masks are MSB-first (bit 3 = R1/T1), so reverse them into code order.
    assign en_s = {rsel[0], rsel[1], rsel[2], rsel[3],
                   tsel[0], tsel[1], tsel[2], tsel[3]};

    // Next-state for every register: apply funsel when enabled, else hold.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            if (en_s[k]) begin
                regs_d[k] = next_val(regs_q[k], funsel, i);
            end else begin
                regs_d[k] = regs_q[k];
            end
        end
    end

    // Register update with synchronous reset taking priority over any write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 8; k++) begin
                regs_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 8; k++) begin
                regs_q[k] <= regs_d[k];
            end
        end
    end

    // Read ports show pre-edge contents; no write bypass.
    always_comb begin
        o1 = regs_q[o1sel];
        o2 = regs_q[o2sel];
    end

endmodule

// File: tb/tb_register_file.sv
// Directed-vector bench for register_file: stimulus pushes expected read
// values into a scoreboard queue, a negedge monitor pops and compares.
module tb_register_file;

    logic       clk;
    logic       rst;
    logic [7:0] i;
    logic [1:0] funsel;
    logic [3:0] rsel;
    logic [3:0] tsel;
    logic [2:0] o1sel;
    logic [2:0] o2sel;
    logic [7:0] o1;
    logic [7:0] o2;

    typedef struct {
        logic [7:0] e1;
        logic [7:0] e2;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   total;
    int   bad;

    register_file #(.NBits(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .i      (i),
        .funsel (funsel),
        .rsel   (rsel),
        .tsel   (tsel),
        .o1sel  (o1sel),
        .o2sel  (o2sel),
        .o1     (o1),
        .o2     (o2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: at most one expectation per cycle, checked mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            total = total + 1;
            if (o1 !== e.e1 || o2 !== e.e2) begin
                bad = bad + 1;
                $display("FAIL %s: got o1=%h o2=%h, required o1=%h o2=%h",
                         e.name, o1, o2, e.e1, e.e2);
            end
        end
    end

    task automatic drive(input logic r, input logic [1:0] fs, input logic [3:0] rs,
                         input logic [3:0] ts, input logic [7:0] d);
        rst = r; funsel = fs; rsel = rs; tsel = ts; i = d;
    endtask

    task automatic expect_rd(input logic [2:0] s1, input logic [2:0] s2,
                             input logic [7:0] e1, input logic [7:0] e2, input string nm);
        exp_t e;
        o1sel = s1; o2sel = s2;
        e.e1 = e1; e.e2 = e2; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] mapv [8];
        logic [7:0] finalv [8];
        logic [2:0] k3;
        total = 0;
        bad   = 0;
        o1sel = 3'b000;
        o2sel = 3'b000;
        drive(1'b1, 2'b00, 4'b0000, 4'b0000, 8'h00);
        tick();
        tick();

        // Reset: load AA everywhere, then reset with a conflicting load.
        drive(1'b0, 2'b01, 4'b1111, 4'b1111, 8'hAA);
        tick();
        drive(1'b1, 2'b01, 4'b1111, 4'b1111, 8'hFF);
        expect_rd(3'b100, 3'b000, 8'hAA, 8'hAA, "pre_reset_aa");
        tick();
        drive(1'b0, 2'b01, 4'b0000, 4'b0000, 8'hFF);
        for (int k = 0; k < 8; k++) begin
            k3 = 3'(k);
            expect_rd(k3, ~k3, 8'h00, 8'h00, "reset_zero");
            tick();
        end

        // Load one register per cycle.
        drive(1'b0, 2'b01, 4'b1000, 4'b0000, 8'h11); tick();
        drive(1'b0, 2'b01, 4'b0100, 4'b0000, 8'h22); tick();
        drive(1'b0, 2'b01, 4'b0010, 4'b0000, 8'h33); tick();
        drive(1'b0, 2'b01, 4'b0001, 4'b0000, 8'h44); tick();
        drive(1'b0, 2'b01, 4'b0000, 4'b1000, 8'h55); tick();
        drive(1'b0, 2'b01, 4'b0000, 4'b0100, 8'h66); tick();
        drive(1'b0, 2'b01, 4'b0000, 4'b0010, 8'h77); tick();
        drive(1'b0, 2'b01, 4'b0000, 4'b0001, 8'h88); tick();
        mapv = '{8'h55, 8'h66, 8'h77, 8'h88, 8'h11, 8'h22, 8'h33, 8'h44};
        drive(1'b0, 2'b11, 4'b0000, 4'b0000, 8'h00);
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k < 8; k++) begin
                k3 = 3'(k);
                expect_rd(k3, ~k3, mapv[k], mapv[7-k], "load_readback");
                tick();
            end
        end

        // Increment wrap on R2.
        drive(1'b0, 2'b01, 4'b0100, 4'b0000, 8'hFE); tick();
        drive(1'b0, 2'b11, 4'b0100, 4'b0000, 8'h00);
        expect_rd(3'b101, 3'b100, 8'hFE, 8'h11, "inc_pre");  tick();
        expect_rd(3'b101, 3'b100, 8'hFF, 8'h11, "inc_ff");   tick();
        expect_rd(3'b101, 3'b110, 8'h00, 8'h33, "inc_wrap"); tick();
        drive(1'b0, 2'b11, 4'b0000, 4'b0000, 8'h00);
        expect_rd(3'b101, 3'b111, 8'h01, 8'h44, "inc_01");   tick();
        expect_rd(3'b000, 3'b011, 8'h55, 8'h88, "inc_others_t"); tick();

        // Decrement wrap on T1 and T4 together.
        drive(1'b0, 2'b01, 4'b0000, 4'b1000, 8'h01); tick();
        drive(1'b0, 2'b01, 4'b0000, 4'b0001, 8'h10); tick();
        drive(1'b0, 2'b10, 4'b0000, 4'b1001, 8'h00);
        expect_rd(3'b000, 3'b011, 8'h01, 8'h10, "dec_pre");  tick();
        expect_rd(3'b000, 3'b011, 8'h00, 8'h0F, "dec_one");  tick();
        drive(1'b0, 2'b10, 4'b0000, 4'b0000, 8'h00);
        expect_rd(3'b000, 3'b011, 8'hFF, 8'h0E, "dec_wrap"); tick();
        expect_rd(3'b001, 3'b010, 8'h66, 8'h77, "dec_others"); tick();

        // Same-edge read on R3, then hold with no enables across all funsels.
        drive(1'b0, 2'b01, 4'b0010, 4'b0000, 8'h3C); tick();
        drive(1'b0, 2'b01, 4'b0010, 4'b0000, 8'hC3);
        expect_rd(3'b110, 3'b110, 8'h3C, 8'h3C, "same_edge_pre"); tick();
        drive(1'b0, 2'b01, 4'b0000, 4'b0000, 8'h5A);
        expect_rd(3'b110, 3'b110, 8'hC3, 8'hC3, "same_edge_post"); tick();
        for (int f = 0; f < 4; f++) begin
            drive(1'b0, 2'(f), 4'b0000, 4'b0000, 8'h5A);
            tick();
        end
        finalv = '{8'hFF, 8'h66, 8'h77, 8'h0E, 8'h11, 8'h01, 8'hC3, 8'h44};
        for (int k = 0; k < 8; k++) begin
            k3 = 3'(k);
            expect_rd(k3, ~k3, finalv[k], finalv[7-k], "hold_no_enable");
            tick();
        end

        // Reset mid-increment on R1.
        drive(1'b0, 2'b01, 4'b1000, 4'b0000, 8'h00); tick();
        drive(1'b0, 2'b11, 4'b1000, 4'b0000, 8'h00);
        expect_rd(3'b100, 3'b101, 8'h00, 8'h01, "rmid_0"); tick();
        expect_rd(3'b100, 3'b101, 8'h01, 8'h01, "rmid_1"); tick();
        expect_rd(3'b100, 3'b101, 8'h02, 8'h01, "rmid_2"); tick();
        drive(1'b1, 2'b11, 4'b1000, 4'b0000, 8'h00);
        expect_rd(3'b100, 3'b101, 8'h03, 8'h01, "rmid_3"); tick();
        drive(1'b0, 2'b11, 4'b1000, 4'b0000, 8'h00);
        expect_rd(3'b100, 3'b101, 8'h00, 8'h00, "rmid_reset"); tick();
        drive(1'b0, 2'b11, 4'b0000, 4'b0000, 8'h00);
        expect_rd(3'b100, 3'b010, 8'h01, 8'h00, "rmid_resume"); tick();

        for (int n = 0; n < 10 && sb.size() > 0; n++) begin
            tick();
        end
        if (sb.size() > 0) begin
            total = total + 1;
            bad   = bad + 1;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
